// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the buffer RAM port arbiter.
package mem_arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_NUM_REQ    = 4;

  // Widest requester vector the index helper accepts.
  localparam int MAX_REQ  = 32;
  localparam int MAX_ID_W = 5;

  // Index of the set bit in a one-hot (or zero) vector; zero maps to 0.
  function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = idx | MAX_ID_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/dual_port_memory.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read and write to the same address on one edge returns the old word.
module dual_port_memory #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  wclk,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rclk,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port
  always_ff @(posedge wclk)
    if (wen) mem[waddr] <= wdata;

  // Registered read port; samples the array before this edge's write lands
  always_ff @(posedge rclk)
    if (ren) rdata <= mem[raddr];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant scanning from a priority pointer,
// pointer moves one past the winner on each granting edge.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx
);

  // One extra bit so ptr+k (< 2N) can be reduced mod N without overflow.
  localparam logic [ID_W:0] N_W = (ID_W+1)'(N);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic [ID_W:0]   pos;
  logic            found;

  // First requester at or after ptr wins; nothing granted while in reset
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (ID_W+1)'(k);
      if (pos >= N_W) pos = pos - N_W;
      if (!found && req[pos[ID_W-1:0]]) begin
        gnt[pos[ID_W-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
    if (!rst_n) gnt = '0;
  end

  assign gnt_idx = ID_W'(onehot_to_idx(MAX_REQ'(gnt)));
  // Wrap at N, not 2**ID_W, so non-power-of-2 requester counts work
  assign ptr_nxt = (gnt_idx == ID_W'(N-1)) ? '0 : gnt_idx + ID_W'(1);

  // Pointer advances only on a grant
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    ptr <= '0;
    else if (|gnt) ptr <= ptr_nxt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the buffer RAM's write and read ports between NUM_REQ requesters.
// Independent round-robin arbiters per port; read data returns one cycle
// after grant, tagged with the requester index and zeroed when not valid.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            wr_gnt,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            rd_gnt,
  output logic                          rd_valid,
  output logic [ID_W-1:0]               rd_id,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] wr_addr_a, rd_addr_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wr_data_a;
  logic [ID_W-1:0]       wr_idx, rd_idx;
  logic                  wen, ren;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  rd_valid_q;
  logic [ID_W-1:0]       rd_id_q;

  assign wr_addr_a = wr_addr;
  assign wr_data_a = wr_data;
  assign rd_addr_a = rd_addr;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (wr_req),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rd_req),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx)
  );

  assign wen = |wr_gnt;
  assign ren = |rd_gnt;

  dual_port_memory #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .wclk  (clk),
    .wen   (wen),
    .waddr (wr_addr_a[wr_idx]),
    .wdata (wr_data_a[wr_idx]),
    .rclk  (clk),
    .ren   (ren),
    .raddr (rd_addr_a[rd_idx]),
    .rdata (ram_rdata)
  );

  // Track which read is in flight; reset drops it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
    end else begin
      rd_valid_q <= ren;
      rd_id_q    <= rd_idx;
    end

  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign rd_data  = rd_valid_q ? ram_rdata : '0;

endmodule
